mem_write_checker: RTL
======================

// Module: mem_write_checker
// PURPOSE
//  Synthesizable self-check monitor on the data-memory write port of the MIPS core.
//  Matches the store stream against a programmable in-order list of expected (addr,data) writes.
//  Skips stores to a programmable ignore-address set.
//  Reports pass/fail, error class and offending write; used in sim benches and FPGA bring-up.
// PARAMETERS
//  ADDR_W   32    width of dataadr
//  DATA_W   32    width of writedata
//  NUM_EXP  4     depth of expected-write table (>=1)
//  NUM_IGN  2     depth of ignore-address table (>=1)
//  TIMEOUT  1024  cycles allowed between arm/last match and next match (MWC_TIMEOUT_EN only)
// PORTS
//  clk        in   1                            rising-edge clock
//  reset      in   1                            asynchronous, active-low reset
//  start      in   1                            pulse: clear status and arm checker
//  memwrite   in   1                            core store strobe, sampled on rising clk
//  dataadr    in   ADDR_W                       store address
//  writedata  in   DATA_W                       store data
//  cfg_we     in   1                            table write strobe (ignored while ARMED)
//  cfg_ign    in   1                            0: expected table, 1: ignore table
//  cfg_idx    in   $clog2(max(NUM_EXP,NUM_IGN)) entry index
//  cfg_addr   in   ADDR_W                       entry address
//  cfg_data   in   DATA_W                       entry data (expected table only)
//  cfg_valid  in   1                            entry valid bit written with entry
//  armed      out  1                            FSM in ARMED
//  done       out  1                            FSM in PASS or FAIL
//  pass       out  1                            FSM in PASS
//  err_code   out  2                            0 none, 1 data mismatch, 2 timeout, 3 unexpected address
//  match_cnt  out  $clog2(NUM_EXP+1)            expected writes matched so far
//  fail_addr  out  ADDR_W                       dataadr of failing store (0 on timeout)
//  fail_data  out  DATA_W                       writedata of failing store (0 on timeout)
// BEHAVIOUR
//  - Reset (async assert, sync release): FSM=IDLE, all table valid bits 0, all outputs 0.
//  - Tables are register arrays; a cfg_we write takes effect next cycle. Out-of-range cfg_idx is dropped.
//  - Number of expected writes N = count of contiguous valid entries from index 0.
//  - States: IDLE -> ARMED on start. PASS/FAIL -> ARMED on start. ARMED ignores start.
//  - Arming clears match_cnt, err_code, fail_addr, fail_data and the timeout counter.
//  - N==0 at arm: go to PASS on the following cycle.
//  - ARMED, memwrite=1, each cycle, in priority order:
//    1. dataadr equals any valid ignore entry: no effect.
//    2. dataadr==exp[match_cnt].addr and writedata==exp[match_cnt].data:
//       match_cnt++, timeout counter cleared; if new match_cnt==N go to PASS.
//    3. dataadr==exp[match_cnt].addr, data differs: FAIL, err_code=1.
//    4. Otherwise: FAIL, err_code=3.
//    On FAIL, fail_addr/fail_data capture the store.
//  - Latency: pass/done/err_code update on the clock edge that samples the deciding store,
//    visible one cycle after memwrite.
//  - memwrite outside ARMED: ignored. Status is held in PASS/FAIL until start or reset.
//  - start and memwrite in the same cycle from PASS/FAIL: start wins; the store is not checked.
//  - Reset mid-run: immediate return to IDLE, tables cleared.
// CONFIGURATION
//  MWC_TIMEOUT_EN defined:
//    - A cycle counter runs in ARMED, cleared on arm and on each match.
//    - Reaching TIMEOUT-1 with no decision: FAIL, err_code=2, fail_addr=fail_data=0.
//    - A match or fail decided on that same cycle takes precedence over the timeout.
//  MWC_TIMEOUT_EN undefined:
//    - No counter is implemented; ARMED waits indefinitely.
//    - err_code=2 is never produced.
// TESTING
//  1. exp0=(84,7), ign0=80, start; stores (80,x),(84,7) -> next cycle pass=1, done=1, match_cnt=1, err_code=0.
//  2. exp0=(84,7); store (84,6) -> pass=0, done=1, err_code=1, fail_addr=84, fail_data=6.
//  3. exp0=(84,7), no ignore entries; store (88,7) -> err_code=3, fail_addr=88.
//  4. exp0..2=(4,1),(8,2),(12,3); stores in order -> match_cnt steps 1,2,3, then pass=1.
//     Out of order (8,2) first -> err_code=1? no: addr 8 != 4, so err_code=3.
//  5. MWC_TIMEOUT_EN, TIMEOUT=16; arm, no stores -> done=1, err_code=2 after 16 cycles.
//     Without the macro: still armed=1 after 1000 cycles.
//  6. reset low while ARMED with match_cnt=1 -> all outputs 0 immediately.
//     After release, a start with empty tables -> pass=1.

Source files
------------

// File: rtl/mem_write_checker.sv
// Store-stream monitor: matches data-memory writes against an in-order expected table,
// skipping an ignore-address set. Optional watchdog enabled by defining MWC_TIMEOUT_EN.
module mem_write_checker #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_EXP = 4,
  parameter int NUM_IGN = 2,
  parameter int TIMEOUT = 1024,
  localparam int MAXN   = (NUM_EXP > NUM_IGN) ? NUM_EXP : NUM_IGN,
  localparam int IDX_W  = (MAXN > 1) ? $clog2(MAXN) : 1,
  localparam int CNT_W  = $clog2(NUM_EXP + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              memwrite,
  input  logic [ADDR_W-1:0] dataadr,
  input  logic [DATA_W-1:0] writedata,
  input  logic              cfg_we,
  input  logic              cfg_ign,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              armed,
  output logic              done,
  output logic              pass,
  output logic [1:0]        err_code,
  output logic [CNT_W-1:0]  match_cnt,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data
);

  typedef enum logic [1:0] {IDLE, ARMED, PASSED, FAILED} state_t;

  localparam logic [1:0] ERR_DATA = 2'd1;
  localparam logic [1:0] ERR_ADDR = 2'd3;

  state_t state;

  logic [ADDR_W-1:0] exp_addr [NUM_EXP];
  logic [DATA_W-1:0] exp_data [NUM_EXP];
  logic [NUM_EXP-1:0] exp_vld;
  logic [ADDR_W-1:0] ign_addr [NUM_IGN];
  logic [NUM_IGN-1:0] ign_vld;

  logic [CNT_W-1:0]  n_exp;
  logic [CNT_W-1:0]  match_nxt;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_data;
  logic              ign_hit;
  logic              cfg_ok;
  logic              run;

  assign cfg_ok    = cfg_we && (state != ARMED);
  assign match_nxt = match_cnt + CNT_W'(1);

  // Valid bits are control and cleared by reset; entry contents are plain data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      exp_vld <= '0;
      ign_vld <= '0;
    end else if (cfg_ok) begin
      for (int i = 0; i < NUM_EXP; i++)
        if (!cfg_ign && cfg_idx == IDX_W'(i)) exp_vld[i] <= cfg_valid;
      for (int i = 0; i < NUM_IGN; i++)
        if (cfg_ign && cfg_idx == IDX_W'(i)) ign_vld[i] <= cfg_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (cfg_ok) begin
      for (int i = 0; i < NUM_EXP; i++)
        if (!cfg_ign && cfg_idx == IDX_W'(i)) begin
          exp_addr[i] <= cfg_addr;
          exp_data[i] <= cfg_data;
        end
      for (int i = 0; i < NUM_IGN; i++)
        if (cfg_ign && cfg_idx == IDX_W'(i)) ign_addr[i] <= cfg_addr;
    end
  end

  // N stops at the first invalid entry so holes truncate the expected list.
  always_comb begin
    n_exp = '0;
    run   = 1'b1;
    for (int i = 0; i < NUM_EXP; i++) begin
      if (run && exp_vld[i]) n_exp = n_exp + CNT_W'(1);
      else run = 1'b0;
    end
  end

  always_comb begin
    cur_addr = '0;
    cur_data = '0;
    for (int i = 0; i < NUM_EXP; i++)
      if (match_cnt == CNT_W'(i)) begin
        cur_addr = exp_addr[i];
        cur_data = exp_data[i];
      end
  end

  always_comb begin
    ign_hit = 1'b0;
    for (int i = 0; i < NUM_IGN; i++)
      if (ign_vld[i] && ign_addr[i] == dataadr) ign_hit = 1'b1;
  end

`ifdef MWC_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TMO_W-1:0] tmo_cnt;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      armed     <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_code  <= 2'd0;
      match_cnt <= '0;
      fail_addr <= '0;
      fail_data <= '0;
`ifdef MWC_TIMEOUT_EN
      tmo_cnt   <= '0;
`endif
    end else begin
      case (state)
        ARMED: begin
          if (n_exp == '0) begin
            state <= PASSED;
            armed <= 1'b0;
            done  <= 1'b1;
            pass  <= 1'b1;
          end else if (memwrite && !ign_hit) begin
            if (dataadr == cur_addr && writedata == cur_data) begin
              match_cnt <= match_nxt;
`ifdef MWC_TIMEOUT_EN
              tmo_cnt   <= '0;
`endif
              if (match_nxt == n_exp) begin
                state <= PASSED;
                armed <= 1'b0;
                done  <= 1'b1;
                pass  <= 1'b1;
              end
            end else begin
              state     <= FAILED;
              armed     <= 1'b0;
              done      <= 1'b1;
              err_code  <= (dataadr == cur_addr) ? ERR_DATA : ERR_ADDR;
              fail_addr <= dataadr;
              fail_data <= writedata;
            end
          end else begin
`ifdef MWC_TIMEOUT_EN
            if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
              state     <= FAILED;
              armed     <= 1'b0;
              done      <= 1'b1;
              err_code  <= 2'd2;
              fail_addr <= '0;
              fail_data <= '0;
            end else begin
              tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
`endif
          end
        end
        default: begin
          if (start) begin
            state     <= ARMED;
            armed     <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_code  <= 2'd0;
            match_cnt <= '0;
            fail_addr <= '0;
            fail_data <= '0;
`ifdef MWC_TIMEOUT_EN
            tmo_cnt   <= '0;
`endif
          end
        end
      endcase
    end
  end

endmodule
